// File: rtl/bitwise_logic_seq.sv
// -----------------------------------------------------------------------------
// bitwise_logic_seq
//
// Purpose: Applies one of eight bitwise operations to two WIDTH-bit operands.
// The work is split into SLICE-bit slices, and one slice is processed per clock,
// starting with the LSB slice. Wide operands can therefore share narrow gate
// logic. The block has a valid/ready handshake on the operand side and on the
// result side. It also reports zero and parity flags for the full result.
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   SLICE  bits processed per cycle; must divide WIDTH exactly
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands and op presented
//   in_ready   out  block can accept (IDLE only)
//   op         in   operation select:
//                     000 AND, 001 OR, 010 XOR, 011 XNOR,
//                     100 NAND, 101 NOR, 110 NOT a, 111 PASS a
//   a, b       in   operands
//   out_valid  out  result and flags valid (DONE)
//   out_ready  in   consumer accepts result
//   result     out  computed result
//   zero       out  result == 0
//   parity     out  XOR-reduction of result
//   busy       out  slices being computed
// -----------------------------------------------------------------------------
module bitwise_logic_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  // Keep the counter at least one bit wide, so that the SLICE == WIDTH case
  // is still legal.
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("bitwise_logic_seq: SLICE must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic               parity_q, parity_d;

  // This is the result register after the current slice has been merged in.
  // The flags on entry to DONE are computed from it. They therefore include
  // the slice that is written on that same edge.
  logic [WIDTH-1:0]   merged_result;
  logic               last_slice;

  function automatic logic [SLICE-1:0] op_fn(input logic [2:0]       f,
                                             input logic [SLICE-1:0] x,
                                             input logic [SLICE-1:0] y);
    logic [SLICE-1:0] r;
    r = '0;
    case (f)
      3'b000:  r = x & y;
      3'b001:  r = x | y;
      3'b010:  r = x ^ y;
      3'b011:  r = ~(x ^ y);
      3'b100:  r = ~(x & y);
      3'b101:  r = ~(x | y);
      3'b110:  r = ~x;
      default: r = x;
    endcase
    return r;
  endfunction

  // Only the slice selected by the counter changes. Every other slice keeps
  // its current contents.
  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign merged_result[gi*SLICE +: SLICE] =
        (cnt_q == CNT_W'(gi)) ? op_fn(op_q, a_q[gi*SLICE +: SLICE], b_q[gi*SLICE +: SLICE])
                              : result_q[gi*SLICE +: SLICE];
    end
  endgenerate

  assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          op_d     = op;
          result_d = '0;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        result_d = merged_result;
        if (last_slice) begin
          zero_d   = ~|merged_result;
          parity_d = ^merged_result;
          cnt_d    = '0;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_BUSY);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;

endmodule

// File: tb/tb_bitwise_logic_seq.sv
module tb_bitwise_logic_seq;

  logic clk;
  logic rst_n;

  // 8-bit / 2-bit slice instance
  logic       iv8, ir8, ov8, ordy8, z8, p8, bz8;
  logic [2:0] op8;
  logic [7:0] a8, b8, r8;

  // 16-bit / 16-bit slice instance
  logic        iv16, ir16, ov16, ordy16, z16, p16, bz16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, r16;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       p;
  } exp_t;
  exp_t sb[$];

  bitwise_logic_seq #(.WIDTH(8), .SLICE(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .op(op8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy8), .result(r8),
    .zero(z8), .parity(p8), .busy(bz8)
  );

  bitwise_logic_seq #(.WIDTH(16), .SLICE(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16),
    .a(a16), .b(b16), .out_valid(ov16), .out_ready(ordy16), .result(r16),
    .zero(z16), .parity(p16), .busy(bz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference for the operation table (full 8-bit width).
  function automatic logic [7:0] ref8(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    case (f)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x ^ y);
      3'd4: return ~(x & y);
      3'd5: return ~(x | y);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // Wait for in_ready, present one operation for a single edge and push its
  // expected result.
  task automatic accept8(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp_res);
    exp_t e;
    int   n;
    n = 0;
    while (!ir8 && n < 20) begin
      tick();
      n++;
    end
    if (!ir8) chk("in_ready_wait_timeout", {15'd0, ir8}, 16'd1);
    iv8 = 1'b1; op8 = f; a8 = x; b8 = y;
    tick();
    iv8 = 1'b0;
    e.res = exp_res; e.z = ~|exp_res; e.p = ^exp_res;
    sb.push_back(e);
  endtask

  // Count cycles to out_valid, pop the scoreboard and compare. Optionally
  // complete the output handshake.
  task automatic finish8(input string tag, input int exp_lat, input bit drain);
    exp_t e;
    int   lat;
    lat = 0;
    while (!ov8 && lat < 50) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 16'd0, 16'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, {8'd0, r8}, {8'd0, e.res});
      chk({tag, "_zero"},   {15'd0, z8}, {15'd0, e.z});
      chk({tag, "_parity"}, {15'd0, p8}, {15'd0, e.p});
    end
    if (drain) begin
      ordy8 = 1'b1;
      tick();
      ordy8 = 1'b0;
      chk({tag, "_in_ready_after"}, {15'd0, ir8}, 16'd1);
    end
  endtask

  logic [2:0] sweep_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [7:0] sweep_exp [8] = '{8'h0F, 8'hFF, 8'hF0, 8'h0F, 8'hF0, 8'h00, 8'hF0, 8'h0F};

  initial begin
    exp_t       held;
    logic [7:0] held_r;
    logic       held_z, held_p;
    int         n;

    rst_n = 1'b0;
    iv8 = 0; ordy8 = 0; op8 = 0; a8 = 0; b8 = 0;
    iv16 = 0; ordy16 = 0; op16 = 0; a16 = 0; b16 = 0;
    #12;
    // Reset values
    chk("rst_in_ready",  {15'd0, ir8}, 16'd1);
    chk("rst_out_valid", {15'd0, ov8}, 16'd0);
    chk("rst_busy",      {15'd0, bz8}, 16'd0);
    chk("rst_result",    {8'd0, r8},   16'd0);
    chk("rst_zero",      {15'd0, z8},  16'd0);
    chk("rst_parity",    {15'd0, p8},  16'd0);
    chk("rst16_in_ready", {15'd0, ir16}, 16'd1);
    chk("rst16_result",   r16,           16'd0);
    rst_n = 1'b1;
    tick();

    // XNOR directed case
    accept8(3'b011, 8'hF0, 8'h3C, 8'h33);
    chk("xnor_busy", {15'd0, bz8}, 16'd1);
    chk("xnor_in_ready_busy", {15'd0, ir8}, 16'd0);
    finish8("xnor", 4, 1'b1);

    // Sweep all ops against the fixed result table
    for (int i = 0; i < 8; i++) begin
      accept8(sweep_op[i], 8'h0F, 8'hFF, sweep_exp[i]);
      finish8($sformatf("sweep_op%0d", i), 4, 1'b1);
      chk($sformatf("sweep_ref_op%0d", i), {8'd0, ref8(sweep_op[i], 8'h0F, 8'hFF)}, {8'd0, sweep_exp[i]});
    end

    // Flag corner cases
    accept8(3'b010, 8'hAA, 8'hAA, 8'h00);
    finish8("xor_zero", 4, 1'b1);
    accept8(3'b001, 8'h01, 8'h00, 8'h01);
    finish8("or_parity", 4, 1'b1);

    // Backpressure: hold DONE for 5 cycles while a second request waits
    accept8(3'b000, 8'hC3, 8'h5A, 8'h42);
    finish8("bp", 4, 1'b0);
    held_r = r8; held_z = z8; held_p = p8;
    iv8 = 1'b1; op8 = 3'b001; a8 = 8'h10; b8 = 8'h03;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_out_valid_c%0d", i), {15'd0, ov8}, 16'd1);
      chk($sformatf("bp_result_c%0d", i), {8'd0, r8}, {8'd0, held_r});
      chk($sformatf("bp_zero_c%0d", i), {15'd0, z8}, {15'd0, held_z});
      chk($sformatf("bp_parity_c%0d", i), {15'd0, p8}, {15'd0, held_p});
      chk($sformatf("bp_in_ready_c%0d", i), {15'd0, ir8}, 16'd0);
    end
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
    chk("bp_idle_in_ready", {15'd0, ir8}, 16'd1);
    chk("bp_idle_busy", {15'd0, bz8}, 16'd0);
    chk("bp_idle_result_held", {8'd0, r8}, {8'd0, held_r});
    tick();
    iv8 = 1'b0;
    chk("bp_pending_accepted", {15'd0, bz8}, 16'd1);
    held.res = 8'h13; held.z = 1'b0; held.p = 1'b1;
    sb.push_back(held);
    finish8("bp_pending", 4, 1'b1);

    // Inputs change every BUSY cycle; out_ready is held high throughout
    ordy8 = 1'b1;
    accept8(3'b100, 8'h96, 8'h3F, 8'hE9);
    n = 0;
    while (!ov8 && n < 50) begin
      op8 = 3'($urandom_range(0, 7)); a8 = 8'($urandom); b8 = 8'($urandom); iv8 = 1'b1;
      tick();
      n++;
    end
    iv8 = 1'b0;
    chk("chg_latency", 16'(n), 16'd4);
    held = sb.pop_front();
    chk("chg_result", {8'd0, r8}, {8'd0, held.res});
    chk("chg_parity", {15'd0, p8}, {15'd0, held.p});
    tick();
    ordy8 = 1'b0;
    chk("chg_in_ready_after", {15'd0, ir8}, 16'd1);

    // Reset during BUSY
    accept8(3'b111, 8'hFF, 8'h00, 8'hFF);
    tick();
    tick();
    chk("rstb_busy_before", {15'd0, bz8}, 16'd1);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("rstb_in_ready",  {15'd0, ir8}, 16'd1);
    chk("rstb_out_valid", {15'd0, ov8}, 16'd0);
    chk("rstb_busy",      {15'd0, bz8}, 16'd0);
    chk("rstb_result",    {8'd0, r8},   16'd0);
    chk("rstb_zero",      {15'd0, z8},  16'd0);
    chk("rstb_parity",    {15'd0, p8},  16'd0);
    #3;
    rst_n = 1'b1;
    tick();
    accept8(3'b101, 8'h12, 8'h40, 8'hAD);
    finish8("after_rst", 4, 1'b1);

    // Single-slice instance
    iv16 = 1'b1; op16 = 3'b000; a16 = 16'hFFFF; b16 = 16'h8001;
    tick();
    iv16 = 1'b0;
    chk("w16_busy", {15'd0, bz16}, 16'd1);
    chk("w16_out_valid_early", {15'd0, ov16}, 16'd0);
    tick();
    chk("w16_out_valid", {15'd0, ov16}, 16'd1);
    chk("w16_result", r16, 16'h8001);
    chk("w16_parity", {15'd0, p16}, 16'd0);
    chk("w16_zero", {15'd0, z16}, 16'd0);
    ordy16 = 1'b1;
    tick();
    ordy16 = 1'b0;
    chk("w16_in_ready_after", {15'd0, ir16}, 16'd1);

    chk("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_seq.md
# bitwise_logic_seq

Parametrised, sequential successor to the fixed 8-bit per-bit logic gates. It applies one of eight bitwise operations to two WIDTH-bit operands. The operation is processed SLICE bits per clock, LSB slice first, so wide operands can share narrow gate logic. A valid/ready handshake sits on both the input and result sides, and the block reports zero and parity flags on the result. It sits between the operand registers and the ALU result mux.

## Interface
- WIDTH, 8, operand/result width; must be ≥1.
- SLICE, 2, bits processed per cycle; must divide WIDTH exactly. NSLICE = WIDTH/SLICE.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and op presented
- in_ready  output  1  block can accept; high only in IDLE
- op  input  3  operation select (see Operation)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  computed result
- zero  output  1  result == 0
- parity  output  1  XOR-reduction of result (1 = odd count of ones)
- busy  output  1  high in BUSY state

## Operation
- op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 XNOR
  - 100 NAND
  - 101 NOR
  - 110 NOT a (b ignored)
  - 111 PASS a
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready, capture a, b, op into internal registers, clear result register and slice counter, then go to BUSY.
  - BUSY: each cycle, compute slice k (bits k·SLICE+SLICE−1 : k·SLICE) from the captured operands, write it into result, then increment k. After the slice k=NSLICE−1 is written, go to DONE.
  - DONE: out_valid=1. result, zero and parity are held stable. On out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. The a, b, op and in_valid inputs are ignored outside the IDLE handshake. Changes to inputs during BUSY have no effect.
- zero and parity are registered on the transition into DONE and computed from the full result. Their values outside DONE are don't-care but must still be reset-defined.
- result holds its contents after DONE→IDLE until the next accept clears it.
- No new operand is accepted in the DONE→IDLE cycle. A new accept happens at the earliest on the next edge.
- Elaboration fails if WIDTH % SLICE != 0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, zero=0, parity=0, slice counter=0.
- Edge E0: input handshake sampled.
- Edges E1..E_NSLICE: one slice written per edge. busy is high from after E0 until after E_NSLICE.
- out_valid rises after E_NSLICE, so latency from accept to out_valid is NSLICE cycles.
- With out_ready held high: output handshake at E_NSLICE+1, in_ready high after it. Minimum period between accepts is NSLICE+2 cycles.
- SLICE=WIDTH: a single BUSY cycle; out_valid rises 1 cycle after accept.
- Backpressure: out_ready low holds DONE indefinitely. result, zero, parity and out_valid stay unchanged.
- Reset mid-BUSY or mid-DONE: immediate return to reset values; the partial result is discarded.
- out_ready asserted while not in DONE: ignored.

## Test plan
- WIDTH=8, SLICE=2, op=011, a=0xF0, b=0x3C.
  - out_valid exactly 4 cycles after accept.
  - result=0x33, zero=0, parity=0.
- Sweep all eight ops with a=0x0F, b=0xFF. Required results:
  - AND 0x0F, OR 0xFF, XOR 0xF0, XNOR 0x0F
  - NAND 0xF0, NOR 0x00 (zero=1), NOT 0xF0, PASS 0x0F
  - parity=0 for each result.
- op=010 with a=b=0xAA gives result=0x00, zero=1, parity=0. op=001 with a=0x01, b=0x00 gives 0x01, parity=1.
- Hold out_ready low for 5 cycles in DONE.
  - out_valid, result and flags stay stable; in_ready stays 0; a second in_valid pulse is not accepted.
  - After out_ready rises, the pending operation is accepted on the cycle after IDLE is entered.
- Change a, b and op every cycle during BUSY. The result must match the operands captured at E0.
- Assert rst_n low after 2 BUSY cycles.
  - Outputs go to reset values asynchronously.
  - After release, a new operation completes with the correct result.
- WIDTH=16, SLICE=16 instance: op=000, a=0xFFFF, b=0x8001 gives result=0x8001, parity=0, out_valid 1 cycle after accept.
